btn_debounce_multi: RTL and testbench
=====================================

// Module: btn_debounce_multi
// PURPOSE
//  Multi-channel button conditioner for the board UI: NUM_BTN raw pushbuttons in, debounced
//  levels and single-cycle event pulses out (press, release, long-press, auto-repeat).
//  Sits between top-level pad inputs and the mode/parameter control FSMs.
//  Press and release are both debounced. One prescaler is shared by all channels.
// PARAMETERS
//  NUM_BTN       5            number of independent button channels (>=1)
//  CLK_HZ        100_000_000  clk frequency
//  TICK_HZ       1_000        sample-tick rate; TICK_DIV = CLK_HZ/TICK_HZ (>=2)
//  STABLE_TICKS  8            consecutive differing ticks needed to flip o_level (>=1)
//  LONG_TICKS    1000         ticks held after press before o_long fires (>=1)
//  REPEAT_TICKS  200          ticks between o_repeat pulses after o_long; 0 = repeat off
//  ACTIVE_LOW    0            1 = pad reads 0 when pressed; inverted after the synchroniser
// PORTS
//  clk        in   1        system clock
//  reset_n    in   1        asynchronous, active-low reset
//  i_btn      in   NUM_BTN  raw asynchronous button pads
//  o_level    out  NUM_BTN  debounced pressed level (1 = pressed)
//  o_press    out  NUM_BTN  1-clk pulse on debounced 0->1
//  o_release  out  NUM_BTN  1-clk pulse on debounced 1->0
//  o_long     out  NUM_BTN  1-clk pulse, once per press, when the hold reaches LONG_TICKS
//  o_repeat   out  NUM_BTN  1-clk pulse every REPEAT_TICKS after o_long while still held
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0, all counters 0, synchronisers 0, every FSM in
//    IDLE. Deassertion mid-press: the channel re-qualifies the press from scratch.
//  - Sync: each i_btn bit passes through a 2-FF synchroniser and then polarity correction,
//    giving s[i]. s is never used combinationally.
//  - Tick: prescaler counts 0..TICK_DIV-1. tick=1 for exactly the clk where the count wraps.
//    All channel counters advance only on tick.
//  - Integrator, per channel, on each tick:
//      if s!=level: if cnt==STABLE_TICKS-1 then level<=s, cnt<=0; else cnt<=cnt+1
//      else cnt<=0
//    A glitch shorter than STABLE_TICKS ticks never changes o_level.
//  - Edge pulses: o_press/o_release are registered. They assert on the clk after o_level
//    changes and last exactly 1 clk.
//  - Hold FSM, per channel: IDLE -> HELD (on level rise; hcnt=0) -> LONG (on tick with
//    hcnt==LONG_TICKS-1; o_long pulse; rcnt=0).
//    In LONG, on each tick: if REPEAT_TICKS!=0 and rcnt==REPEAT_TICKS-1, pulse o_repeat and
//    set rcnt=0; otherwise rcnt++.
//    A level fall in any state -> IDLE with counters cleared. No o_long or o_repeat pulse is
//    emitted in the cycle of the release or after it.
//  - Simultaneous events: o_long and o_release in the same tick -> release wins, o_long
//    suppressed. Channels are fully independent; any combination may pulse in the same clk.
//  - Widths: cnt = $clog2(STABLE_TICKS+1), hcnt = $clog2(LONG_TICKS+1),
//    rcnt = $clog2(REPEAT_TICKS+1) (min 1). No counter wraps: each is cleared at its
//    terminal value.
//  - Latency, pad change to o_level: 2 clk (sync) plus up to TICK_DIV clk plus
//    (STABLE_TICKS-1)*TICK_DIV clk.
// STRUCTURE
//  - btn_pkg: hold-FSM state encoding (IDLE=2'd0, HELD=2'd1, LONG=2'd2) and a
//    clog2-of-parameter helper.
//  - Sub-module btn_debounce_ch: one channel (sync, integrator, edge pulses, hold FSM),
//    taking tick as an input.
//  - Top: prescaler plus a generate loop of NUM_BTN btn_debounce_ch instances.
// TESTING  (sim params: CLK_HZ=10, TICK_HZ=5 -> TICK_DIV=2, STABLE_TICKS=3, LONG_TICKS=4,
//           REPEAT_TICKS=2, NUM_BTN=2)
//  1 Reset: hold reset_n=0 with i_btn=2'b11 -> all outputs 0. Release reset, keep i_btn=11
//    -> o_level=11 no later than 2+2+4=8 clk; exactly one o_press pulse per channel.
//  2 Glitch: i_btn[0] high for 3 clk (<3 ticks), then low -> o_level[0] stays 0, no pulses.
//  3 Long/repeat: hold i_btn[0] 40 clk -> o_press, then o_long 8 clk (4 ticks) after the
//    press, then o_repeat every 4 clk. Release -> o_release once; no further long/repeat.
//  4 Bounce on release: toggle i_btn[0] low/high every clk for 10 clk, then settle low ->
//    exactly one o_release, only after 3 stable ticks.
//  5 Independence: ch0 held, ch1 pressed and released meanwhile -> ch0 long/repeat cadence
//    unchanged.
//  6 Async reset mid-LONG: pulse reset_n low for 1 clk while ch0 is in LONG -> outputs 0
//    immediately, without a clk edge. After release, a held button yields a fresh o_press.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
package btn_pkg;

   typedef enum logic [1:0] {
      HOLD_IDLE = 2'd0,
      HOLD_HELD = 2'd1,
      HOLD_LONG = 2'd2
   } hold_state_e;

   // Bits needed to count 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-driven integrator, edge pulses and hold FSM.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int STABLE_TICKS = 8,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int CNT_W  = cnt_width(STABLE_TICKS);
   localparam int HCNT_W = cnt_width(LONG_TICKS);
   localparam int RCNT_W = cnt_width(REPEAT_TICKS);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_TICKS - 1);
   localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_TICKS - 1);
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
   localparam logic POLARITY = (ACTIVE_LOW != 0);

   logic [1:0]        sync_q;
   logic              s;
   logic              level_q, level_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rise, fall;
   hold_state_e       state_q, state_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic              long_evt, rep_evt;
   logic              rise_q, fall_q, long_q, rep_q;

   assign s       = sync_q[1] ^ POLARITY;
   assign o_level = level_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      level_d = level_q;
      cnt_d   = cnt_q;
      if (tick) begin
         if (s != level_q) begin
            if (cnt_q == CNT_LAST) begin
               level_d = s;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else begin
            cnt_d = '0;
         end
      end
      rise = level_d & ~level_q;
      fall = ~level_d & level_q;
   end

   // A fall takes priority over any long/repeat event due on the same tick.
   always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      rcnt_d   = rcnt_q;
      long_evt = 1'b0;
      rep_evt  = 1'b0;
      unique case (state_q)
         HOLD_IDLE: begin
            if (rise) begin
               state_d = HOLD_HELD;
               hcnt_d  = '0;
            end
         end
         HOLD_HELD: begin
            if (fall) begin
               state_d = HOLD_IDLE;
               hcnt_d  = '0;
            end else if (tick) begin
               if (hcnt_q == HCNT_LAST) begin
                  state_d  = HOLD_LONG;
                  long_evt = 1'b1;
                  hcnt_d   = '0;
                  rcnt_d   = '0;
               end else begin
                  hcnt_d = hcnt_q + 1'b1;
               end
            end
         end
         HOLD_LONG: begin
            if (fall) begin
               state_d = HOLD_IDLE;
               rcnt_d  = '0;
            end else if (tick && (REPEAT_TICKS != 0)) begin
               if (rcnt_q == RCNT_LAST) begin
                  rep_evt = 1'b1;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end
         default: state_d = HOLD_IDLE;
      endcase
   end

   // Events are staged one clk so every pulse trails its state change by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         sync_q    <= '0;
         level_q   <= 1'b0;
         cnt_q     <= '0;
         state_q   <= HOLD_IDLE;
         hcnt_q    <= '0;
         rcnt_q    <= '0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         long_q    <= 1'b0;
         rep_q     <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_long    <= 1'b0;
         o_repeat  <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], i_btn};
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         rcnt_q    <= rcnt_d;
         rise_q    <= rise;
         fall_q    <= fall;
         long_q    <= long_evt;
         rep_q     <= rep_evt;
         o_press   <= rise_q;
         o_release <= fall_q;
         o_long    <= long_q;
         o_repeat  <= rep_q;
      end
   end

endmodule

// File: rtl/btn_debounce_multi.sv
// Multi-channel button conditioner: one shared sample-tick prescaler feeding NUM_BTN channels.
module btn_debounce_multi
   import btn_pkg::*;
#(
   parameter int NUM_BTN      = 5,
   parameter int CLK_HZ       = 100_000_000,
   parameter int TICK_HZ      = 1_000,
   parameter int STABLE_TICKS = 8,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_BTN-1:0] i_btn,
   output logic [NUM_BTN-1:0] o_level,
   output logic [NUM_BTN-1:0] o_press,
   output logic [NUM_BTN-1:0] o_release,
   output logic [NUM_BTN-1:0] o_long,
   output logic [NUM_BTN-1:0] o_repeat
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PCNT_W   = cnt_width(TICK_DIV - 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

   logic [PCNT_W-1:0] pcnt_q;
   logic              tick;

   assign tick = (pcnt_q == PCNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  pcnt_q <= '0;
      else if (tick) pcnt_q <= '0;
      else           pcnt_q <= pcnt_q + 1'b1;
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
         .clk       (clk),
         .reset_n   (reset_n),
         .tick      (tick),
         .i_btn     (i_btn[i]),
         .o_level   (o_level[i]),
         .o_press   (o_press[i]),
         .o_release (o_release[i]),
         .o_long    (o_long[i]),
         .o_repeat  (o_repeat[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: TICK_DIV=2, STABLE=3, LONG=4, REPEAT=2, two channels.
module tb_btn_debounce_multi;

   localparam int NUM_BTN = 2;

   typedef enum int {K_PRESS, K_RELEASE, K_LONG, K_REPEAT} kind_e;
   typedef struct {
      kind_e kind;
      int    cyc;
   } exp_t;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] btn     = 2'b11;
   logic [1:0] level, press, rls, lng, rpt;

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   btn_debounce_multi #(
      .NUM_BTN      (NUM_BTN),
      .CLK_HZ       (10),
      .TICK_HZ      (5),
      .STABLE_TICKS (3),
      .LONG_TICKS   (4),
      .REPEAT_TICKS (2),
      .ACTIVE_LOW   (0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_btn     (btn),
      .o_level   (level),
      .o_press   (press),
      .o_release (rls),
      .o_long    (lng),
      .o_repeat  (rpt)
   );

   always #5 clk = ~clk;

   // Edges since the last reset release; ticks land on even counts.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   function automatic string kind_name(input kind_e k);
      case (k)
         K_PRESS:   return "press";
         K_RELEASE: return "release";
         K_LONG:    return "long";
         default:   return "repeat";
      endcase
   endfunction

   function automatic void expect_pulse(input int ch, input kind_e k, input int c);
      exp_t e;
      e.kind = k;
      e.cyc  = c;
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic mon_pulse(input int ch, input kind_e k);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (ch == 0 && q0.size() > 0) begin
         e    = q0.pop_front();
         have = 1'b1;
      end else if (ch == 1 && q1.size() > 0) begin
         e    = q1.pop_front();
         have = 1'b1;
      end
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL ch%0d pulse: got %s at cyc %0d, expected none", ch, kind_name(k), cyc);
      end else if (e.kind != k || e.cyc != cyc) begin
         errors++;
         $display("FAIL ch%0d pulse: got %s at cyc %0d, expected %s at cyc %0d",
                  ch, kind_name(k), cyc, kind_name(e.kind), e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         for (int ch = 0; ch < NUM_BTN; ch++) begin
            if (press[ch]) mon_pulse(ch, K_PRESS);
            if (rls[ch])   mon_pulse(ch, K_RELEASE);
            if (lng[ch])   mon_pulse(ch, K_LONG);
            if (rpt[ch])   mon_pulse(ch, K_REPEAT);
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " level"},   32'(level), 32'd0);
      check({tag, " press"},   32'(press), 32'd0);
      check({tag, " release"}, 32'(rls),   32'd0);
      check({tag, " long"},    32'(lng),   32'd0);
      check({tag, " repeat"},  32'(rpt),   32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset held with both pads pressed, then released at a negedge (cyc 0).
      repeat (4) @(negedge clk);
      check_all_zero("in reset");
      reset_n = 1'b1;
      // Release driven on the qualifying edge: long due on the same tick as the fall, so suppressed.
      for (int ch = 0; ch < NUM_BTN; ch++) begin
         expect_pulse(ch, K_PRESS, 9);
         expect_pulse(ch, K_RELEASE, 17);
      end
      wait_cyc(7);  check("level before qualify", 32'(level), 32'd0);
      wait_cyc(8);  check("level at 8 clk", 32'(level), 32'd3);
      btn = 2'b00;
      wait_cyc(15); check("level before fall", 32'(level), 32'd3);
      wait_cyc(16); check("level after fall", 32'(level), 32'd0);

      // Glitches of one and two ticks on ch0 never reach o_level.
      wait_cyc(20); btn = 2'b01;
      wait_cyc(23); btn = 2'b00;
      wait_cyc(30); check("level after 1-tick glitch", 32'(level), 32'd0);
      wait_cyc(32); btn = 2'b01;
      wait_cyc(37); btn = 2'b00;
      wait_cyc(44); check("level after 2-tick glitch", 32'(level), 32'd0);

      // Long press with repeats; the repeat due on the release tick is suppressed.
      expect_pulse(0, K_PRESS, 55);
      expect_pulse(0, K_LONG, 63);
      for (int c = 67; c <= 91; c += 4) expect_pulse(0, K_REPEAT, c);
      expect_pulse(0, K_RELEASE, 95);
      wait_cyc(46); btn = 2'b01;
      wait_cyc(53); check("level before press", 32'(level), 32'd0);
      wait_cyc(54); check("level pressed", 32'(level), 32'd1);
      wait_cyc(86); btn = 2'b00;
      wait_cyc(94); check("level released", 32'(level), 32'd0);

      // Bouncing release: exactly one release after three stable ticks.
      expect_pulse(0, K_PRESS, 109);
      expect_pulse(0, K_LONG, 117);
      expect_pulse(0, K_REPEAT, 121);
      expect_pulse(0, K_REPEAT, 125);
      expect_pulse(0, K_RELEASE, 129);
      wait_cyc(100); btn = 2'b01;
      for (int n = 110; n < 120; n++) begin
         wait_cyc(n);
         btn = (n % 2 == 1) ? 2'b01 : 2'b00;
      end
      wait_cyc(120); btn = 2'b00;
      check("level during bounce", 32'(level), 32'd1);
      wait_cyc(127); check("level before bounce fall", 32'(level), 32'd1);
      wait_cyc(128); check("level after bounce fall", 32'(level), 32'd0);

      // ch1 pressed and released while ch0 runs its long/repeat cadence.
      expect_pulse(0, K_PRESS, 143);
      expect_pulse(0, K_LONG, 151);
      for (int c = 155; c <= 171; c += 4) expect_pulse(0, K_REPEAT, c);
      expect_pulse(0, K_RELEASE, 173);
      expect_pulse(1, K_PRESS, 153);
      expect_pulse(1, K_RELEASE, 159);
      wait_cyc(134); btn = 2'b01;
      wait_cyc(144); btn = 2'b11;
      wait_cyc(150); btn = 2'b01;
      wait_cyc(152); check("both levels high", 32'(level), 32'd3);
      wait_cyc(164); btn = 2'b00;
      wait_cyc(172); check("levels after independence", 32'(level), 32'd0);

      // Async reset while ch0 is in LONG, then a fresh press from scratch.
      expect_pulse(0, K_PRESS, 187);
      expect_pulse(0, K_LONG, 195);
      expect_pulse(0, K_REPEAT, 199);
      expect_pulse(0, K_REPEAT, 203);
      wait_cyc(178); btn = 2'b01;
      wait_cyc(204); check("level held before reset", 32'(level), 32'd1);
      #1 reset_n = 1'b0;
      #1 check_all_zero("async reset");
      @(negedge clk);
      reset_n = 1'b1;
      expect_pulse(0, K_PRESS, 9);
      expect_pulse(0, K_LONG, 17);
      expect_pulse(0, K_RELEASE, 19);
      wait_cyc(8);  check("level after re-qualify", 32'(level), 32'd1);
      wait_cyc(10); btn = 2'b00;
      wait_cyc(24); check("level final", 32'(level), 32'd0);

      wait_cyc(30);
      check("ch0 pulses outstanding", 32'(q0.size()), 32'd0);
      check("ch1 pulses outstanding", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
